// File: rtl/fwd_result_pipe_pkg.sv
// Shared types and constants for the EX/MEM and MEM/WB result pipeline.
package fwd_result_pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

  localparam logic [REG_AW-1:0] X0          = '0;
  localparam stage_t            STAGE_EMPTY = '0;

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage register: async clear, hold (freeze) and bubble insert.
// Bubble wins over hold so a stage can be emptied while its producer waits.
module fwd_stage_reg
  import fwd_result_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   hold,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  // Stage contents: clear on reset, empty on bubble, keep on hold, else load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= STAGE_EMPTY;
    end else if (bubble) begin
      q <= STAGE_EMPTY;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fwd_result_pipe.sv
// EX/MEM and MEM/WB pipeline registers, load handshake, stall generation,
// writeback, and the two forwarding tag/data pairs.
//
// Handshake: mem_req is held high while EX/MEM holds a load; the load
// completes in any cycle where mem_req=1 and mem_ready=1. mem_ready is
// ignored while mem_req=0. Every cycle with mem_req=1 and mem_ready=0 freezes
// EX/MEM, inserts a bubble into MEM/WB and raises stall.
module fwd_result_pipe
  import fwd_result_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              flush,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  output logic [REG_AW-1:0] exmem_rd,
  output logic [XLEN-1:0]   exmem_data,
  output logic [REG_AW-1:0] memwb_rd,
  output logic [XLEN-1:0]   memwb_data,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              bubble_ex,
  output state_t            dbg_state,
  output logic              dbg_wb_load
);

  state_t state_q, state_d;
  stage_t exmem_d, exmem_q;
  stage_t memwb_d, memwb_q;
  logic   freeze;
  logic   load_use;
  logic   exmem_pub;
  logic   memwb_pub;

  // Load waiting on memory: freeze EX/MEM, bubble MEM/WB.
  assign mem_req  = exmem_q.valid & exmem_q.mem_read;
  assign mem_addr = mem_req ? exmem_q.data : '0;
  assign freeze   = mem_req & ~mem_ready;

  // Load in EX whose rd is a source of the instruction in ID.
  assign load_use = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != X0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Freeze dominates: while frozen, ID/EX is held rather than bubbled.
  assign stall     = freeze | load_use;
  assign bubble_ex = load_use & ~freeze;

  // EX/MEM next value; a flushed EX instruction enters as invalid.
  always_comb begin
    exmem_d           = STAGE_EMPTY;
    exmem_d.valid     = ex_valid & ~flush;
    exmem_d.rd        = ex_rd;
    exmem_d.data      = ex_result;
    exmem_d.reg_write = ex_reg_write;
    exmem_d.mem_read  = ex_mem_read;
  end

  // MEM/WB next value: load data for loads, ALU result otherwise.
  always_comb begin
    memwb_d           = STAGE_EMPTY;
    memwb_d.valid     = exmem_q.valid & exmem_q.reg_write;
    memwb_d.rd        = exmem_q.rd;
    memwb_d.data      = exmem_q.mem_read ? mem_rdata : exmem_q.data;
    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.mem_read  = exmem_q.mem_read;
  end

  fwd_stage_reg u_exmem (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (freeze),
    .bubble  (1'b0),
    .d       (exmem_d),
    .q       (exmem_q)
  );

  fwd_stage_reg u_memwb (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (1'b0),
    .bubble  (freeze),
    .d       (memwb_d),
    .q       (memwb_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: wait while a pending load sees mem_ready low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze)    state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Published tags: x0 unless the stage holds a written, non-x0 result whose
  // data is already known (a load in EX/MEM has no data yet).
  assign exmem_pub  = exmem_q.valid & exmem_q.reg_write & ~exmem_q.mem_read &
                      (exmem_q.rd != X0);
  assign memwb_pub  = memwb_q.valid & memwb_q.reg_write & (memwb_q.rd != X0);

  assign exmem_rd   = exmem_pub ? exmem_q.rd   : X0;
  assign exmem_data = exmem_pub ? exmem_q.data : '0;
  assign memwb_rd   = memwb_pub ? memwb_q.rd   : X0;
  assign memwb_data = memwb_pub ? memwb_q.data : '0;

  // MEM/WB is emptied during waits, so each instruction writes once.
  assign wb_en   = memwb_pub;
  assign wb_rd   = memwb_rd;
  assign wb_data = memwb_data;

  assign dbg_state   = state_q;
  assign dbg_wb_load = memwb_q.valid & memwb_q.mem_read;

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed test of fwd_result_pipe with hand-computed expected values.
module tb_fwd_result_pipe;
  import fwd_result_pipe_pkg::*;

  logic              clk;
  logic              reset_n;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_result;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              flush;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;
  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic [REG_AW-1:0] exmem_rd;
  logic [XLEN-1:0]   exmem_data;
  logic [REG_AW-1:0] memwb_rd;
  logic [XLEN-1:0]   memwb_data;
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              stall;
  logic              bubble_ex;
  state_t            dbg_state;
  logic              dbg_wb_load;

  int checks;
  int failures;
  int wb_pulses;

  fwd_result_pipe dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .exmem_rd     (exmem_rd),
    .exmem_data   (exmem_data),
    .memwb_rd     (memwb_rd),
    .memwb_data   (memwb_data),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .bubble_ex    (bubble_ex),
    .dbg_state    (dbg_state),
    .dbg_wb_load  (dbg_wb_load)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_en) wb_pulses++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rw, input logic mr,
                          input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] res);
    ex_valid     = v;
    ex_reg_write = rw;
    ex_mem_read  = mr;
    ex_rd        = rd;
    ex_result    = res;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'h0);
    check({tag, "_mem_addr"},   mem_addr,        32'h0);
    check({tag, "_exmem_rd"},   32'(exmem_rd),   32'h0);
    check({tag, "_exmem_data"}, exmem_data,      32'h0);
    check({tag, "_memwb_rd"},   32'(memwb_rd),   32'h0);
    check({tag, "_memwb_data"}, memwb_data,      32'h0);
    check({tag, "_wb_en"},      32'(wb_en),      32'h0);
    check({tag, "_wb_rd"},      32'(wb_rd),      32'h0);
    check({tag, "_wb_data"},    wb_data,         32'h0);
    check({tag, "_stall"},      32'(stall),      32'h0);
    check({tag, "_bubble_ex"},  32'(bubble_ex),  32'h0);
    check({tag, "_state"},      32'(dbg_state),  32'(RUN));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    wb_pulses = 0;
    reset_n   = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    id_rs1    = '0;
    id_rs2    = '0;
    flush     = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    // Reset
    #12;
    check_all_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // ADD x5 <- 0x10
    drive_ex(1'b1, 1'b1, 1'b0, 5'd5, 32'h10);
    settle();
    check("add_no_stall", 32'(stall), 32'h0);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    check("add_exmem_rd",   32'(exmem_rd), 32'd5);
    check("add_exmem_data", exmem_data,    32'h10);
    check("add_memwb_rd0",  32'(memwb_rd), 32'd0);
    check("add_wb_en0",     32'(wb_en),    32'h0);
    wb_pulses = 0;
    tick();
    check("add_memwb_rd",   32'(memwb_rd),   32'd5);
    check("add_memwb_data", memwb_data,      32'h10);
    check("add_wb_en",      32'(wb_en),      32'h1);
    check("add_wb_rd",      32'(wb_rd),      32'd5);
    check("add_wb_data",    wb_data,         32'h10);
    check("add_exmem_clr",  32'(exmem_rd),   32'd0);
    tick();
    check("add_wb_once",    32'(wb_pulses),  32'd1);

    // LW x6 with dependent rs1 in ID, zero-wait memory
    drive_ex(1'b1, 1'b1, 1'b1, 5'd6, 32'h100);
    id_rs1 = 5'd6;
    settle();
    check("lu_stall",  32'(stall),     32'h1);
    check("lu_bubble", 32'(bubble_ex), 32'h1);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    mem_rdata = 32'hDEADBEEF;
    mem_ready = 1'b1;
    settle();
    check("lw_stall_one",  32'(stall),     32'h0);
    check("lw_bubble_one", 32'(bubble_ex), 32'h0);
    check("lw_exmem_rd",   32'(exmem_rd),  32'd0);
    check("lw_exmem_data", exmem_data,     32'h0);
    check("lw_mem_req",    32'(mem_req),   32'h1);
    check("lw_mem_addr",   mem_addr,       32'h100);
    wb_pulses = 0;
    tick();
    id_rs1    = '0;
    mem_ready = 1'b0;
    settle();
    check("lw_memwb_rd",   32'(memwb_rd),    32'd6);
    check("lw_memwb_data", memwb_data,       32'hDEADBEEF);
    check("lw_wb_en",      32'(wb_en),       32'h1);
    check("lw_wb_load",    32'(dbg_wb_load), 32'h1);
    check("lw_req_done",   32'(mem_req),     32'h0);
    tick();
    check("lw_wb_once",    32'(wb_pulses),   32'd1);

    // LW x8 with three wait cycles
    drive_ex(1'b1, 1'b1, 1'b1, 5'd8, 32'h200);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    mem_ready = 1'b0;
    mem_rdata = 32'h12345678;
    wb_pulses = 0;
    settle();
    check("w1_stall",   32'(stall),     32'h1);
    check("w1_req",     32'(mem_req),   32'h1);
    check("w1_state",   32'(dbg_state), 32'(RUN));
    tick();
    check("w2_state",   32'(dbg_state), 32'(MEM_WAIT));
    check("w2_stall",   32'(stall),     32'h1);
    check("w2_memwb",   32'(memwb_rd),  32'd0);
    check("w2_wb_en",   32'(wb_en),     32'h0);
    // Load-use during the wait, plus a flush: freeze dominates
    drive_ex(1'b1, 1'b1, 1'b1, 5'd9, 32'h300);
    id_rs2 = 5'd9;
    flush  = 1'b1;
    settle();
    check("w2_lu_stall",  32'(stall),     32'h1);
    check("w2_lu_bubble", 32'(bubble_ex), 32'h0);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    id_rs2 = '0;
    flush  = 1'b0;
    settle();
    check("w3_state",   32'(dbg_state), 32'(MEM_WAIT));
    check("w3_stall",   32'(stall),     32'h1);
    check("w3_addr",    mem_addr,       32'h200);
    check("w3_wb_en",   32'(wb_en),     32'h0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE0008;
    settle();
    check("w4_state",   32'(dbg_state), 32'(MEM_WAIT));
    check("w4_stall",   32'(stall),     32'h0);
    tick();
    mem_ready = 1'b0;
    settle();
    check("w_done_state", 32'(dbg_state), 32'(RUN));
    check("w_memwb_rd",   32'(memwb_rd),  32'd8);
    check("w_memwb_data", memwb_data,     32'hCAFE0008);
    check("w_wb_en",      32'(wb_en),     32'h1);
    tick();
    check("w_wb_once",    32'(wb_pulses), 32'd1);

    // Write to x0
    drive_ex(1'b1, 1'b1, 1'b0, 5'd0, 32'h55);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    check("x0_exmem_rd",   32'(exmem_rd), 32'd0);
    check("x0_exmem_data", exmem_data,    32'h0);
    tick();
    check("x0_memwb_rd",   32'(memwb_rd), 32'd0);
    check("x0_memwb_data", memwb_data,    32'h0);
    check("x0_wb_en",      32'(wb_en),    32'h0);

    // Flushed ADD x7
    drive_ex(1'b1, 1'b1, 1'b0, 5'd7, 32'h77);
    flush = 1'b1;
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    flush = 1'b0;
    settle();
    check("fl_exmem_rd", 32'(exmem_rd), 32'd0);
    tick();
    check("fl_memwb_rd", 32'(memwb_rd), 32'd0);
    check("fl_wb_en",    32'(wb_en),    32'h0);

    // Reset during MEM_WAIT abandons the load
    drive_ex(1'b1, 1'b1, 1'b1, 5'd6, 32'h400);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, '0, '0);
    mem_ready = 1'b0;
    tick();
    check("rw_state", 32'(dbg_state), 32'(MEM_WAIT));
    reset_n = 1'b0;
    settle();
    check_all_zero("rw_reset");
    tick();
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h66666666;
    wb_pulses = 0;
    settle();
    check("rw_req", 32'(mem_req), 32'h0);
    tick();
    check("rw_state_run", 32'(dbg_state), 32'(RUN));
    check("rw_memwb_rd",  32'(memwb_rd),  32'd0);
    tick();
    check("rw_no_wb",     32'(wb_pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_result_pipe.md
# fwd_result_pipe

Owns the EX/MEM and MEM/WB pipeline registers of the RV32IM core and publishes the two destination-tag/data pairs that the operand forwarding logic compares against rs1/rs2. It is the producer end of the forwarding interface: it captures EX results, performs the data-memory load handshake, generates load-use and memory-wait stalls, and drives register-file writeback. Sits between the EX stage (ALU/MUL) and the register file.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_reg_write  in  1  EX instruction writes rd
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_AW  EX destination register
- ex_result  in  XLEN  ALU result / load address
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- flush  in  1  branch redirect: kill EX instruction this cycle
- mem_rdata  in  XLEN  load data from data memory
- mem_ready  in  1  data memory completes the pending load this cycle
- mem_req  out  1  load request active (EX/MEM holds a load)
- mem_addr  out  XLEN  load address
- exmem_rd  out  REG_AW  forwarding tag, stage 1
- exmem_data  out  XLEN  forwarding data, stage 1
- memwb_rd  out  REG_AW  forwarding tag, stage 2
- memwb_data  out  XLEN  forwarding data, stage 2
- wb_en  out  1  register-file write enable
- wb_rd  out  REG_AW  write address
- wb_data  out  XLEN  write data
- stall  out  1  hold PC, IF/ID, ID/EX
- bubble_ex  out  1  load NOP into ID/EX

## Operation
- Tag rule: the forwarding consumer compares tags unconditionally, so a published tag is x0 (with data 0) whenever the stage is empty, does not write, targets x0, or is a load still in EX/MEM. Never publish a nonzero tag with stale data.
- EX/MEM capture (when not frozen): valid = ex_valid & ~flush; stores rd, result, reg_write, mem_read.
- Load-use: ex_valid & ex_mem_read & ex_reg_write & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2) → stall=1, bubble_ex=1 for exactly one cycle.
- FSM states RUN, MEM_WAIT:
  - RUN: if EX/MEM holds a valid load and mem_ready=0 → MEM_WAIT; if mem_ready=1, load completes same cycle.
  - MEM_WAIT: stall=1, EX/MEM frozen, MEM/WB loads a bubble; on mem_ready=1 → RUN, MEM/WB captures {rd, mem_rdata}.
- MEM/WB capture: ALU op → ex result; load → mem_rdata; otherwise bubble.
- Writeback: wb_en = MEM/WB valid & reg_write & rd≠0; asserted once per instruction (bubbles during waits guarantee no duplicate write).
- flush in MEM_WAIT: ignored for EX/MEM (older instruction); the ID/EX kill is the front end's job.

## Timing
- Reset (async, reset_n=0): state RUN; all stage valids 0; every output 0 (tags x0, data 0, wb_en 0, mem_req 0, stall 0, bubble_ex 0).
- stall, bubble_ex, mem_req, mem_addr, and published tags are combinational from registered state plus the ex_*/id_*/mem_ready inputs; all storage updates on the rising edge of clk.
- ALU result: EX at cycle N → exmem tag at N+1 → memwb tag at N+2 → written to the RF at the N+2 edge.
- Load, zero wait: EX at N; EX/MEM at N+1 (tag x0, mem_req=1, mem_ready=1); memwb tag/data = load data at N+2.
- Each mem_ready=0 cycle adds one cycle of stall; mem_ready is don't-care when mem_req=0.
- Load-use and MEM_WAIT stall in the same cycle: stall=1, bubble_ex=0 (freeze dominates).
- Reset assertion mid-MEM_WAIT abandons the load; no writeback occurs.

## Structure
- Shared package: REG_AW/XLEN constants, state enum {RUN, MEM_WAIT}, stage-register struct {valid, rd, data, reg_write, mem_read}, and the x0 constant.
- One sub-module: fwd_stage_reg (stage-register struct with async reset, hold enable, and bubble insert), instantiated twice.

## Test plan
- ADD x5 ← 0x10 in EX at cycle 0 → exmem_rd=5/data=0x10 at cycle 1, memwb_rd=5 at cycle 2, wb_en=1 once.
- LW x6 (mem_rdata=0xDEADBEEF, mem_ready=1), next ID uses rs1=6 → stall=1, bubble_ex=1 for one cycle, exmem_rd=0 during the load, memwb_rd=6/data=0xDEADBEEF next cycle.
- LW with mem_ready low for 3 cycles → stall=1 for 3 cycles, FSM in MEM_WAIT, memwb bubbles, a single wb_en pulse.
- Write to x0 (ex_rd=0, result 0x55) → all tags 0, data 0, wb_en=0.
- flush=1 with a valid ADD x7 in EX → no x7 tag published, no writeback.
- reset_n driven low during MEM_WAIT → all outputs 0 immediately; after release the FSM is in RUN and x6 is not written.
